rs422_axis_rx_framer: RTL and testbench

Parametrised RS-422 synchronous serial receiver that deserialises a clocked bit stream (clock, active-low enable, data) into DATA_W-bit words and emits them as an AXI4-Stream master with a FIFO that honours back-pressure. It extracts a 16-bit length field from each frame header to generate tlast, and closes aborted frames with an error flag. It replaces the fixed 8-bit, unbuffered receiver in the RS-422 → HDLC/DMA receive path.

---
 rtl/rs422_rx_pkg.sv | 24 ++
 rtl/rs422_rx_fifo.sv | 64 ++++++
 rtl/rs422_axis_rx_framer.sv | 215 +++++++++++++++++++++
 tb/tb_rs422_axis_rx_framer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs422_rx_pkg.sv
// Shared constants for the RS-422 receive framer.
//   LEN_W / LEN_BYTE_W : frame length field width and the per-word slice that feeds it
//   DEF_*              : default framing parameters (header offset, overhead words)
//   entry_*            : FIFO entry layout {user, last, data}
package rs422_rx_pkg;

  localparam int LEN_W          = 16;
  localparam int LEN_BYTE_W     = 8;
  localparam int DEF_LEN_OFFSET = 5;
  localparam int DEF_FRAME_OVH  = 7;

  function automatic int entry_w(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int entry_last_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int entry_user_pos(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/rs422_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
//   wr_en/wr_data : push request; ignored while full (caller flags the drop)
//   rd_en/rd_data : pop request; rd_data shows the head entry, zero when empty
//   empty/full    : occupancy flags
//   level         : current number of stored entries
module rs422_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push, pop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == (AW+1)'(DEPTH));
    push     = wr_en && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    // Gate the head so outputs read zero after reset regardless of RAM contents.
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    level   = level_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/rs422_axis_rx_framer.sv
// RS-422 synchronous serial receiver: synchronises clock/enable/data pins,
// deserialises DATA_W-bit words, frames them using the 16-bit header length
// and streams them out through a FWFT FIFO as AXI4-Stream.
//   rs422_clk/en/data : asynchronous serial pins (enable active low)
//   tvalid/tready/tdata/tlast/tuser : AXI-S master, tuser=1 with tlast marks an aborted frame
//   rx_overflow : pulse, a word was dropped because the FIFO was full
//   frame_err   : pulse, a frame was closed early by enable deassert
//   fifo_level  : FIFO occupancy
module rs422_axis_rx_framer
  import rs422_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MSB_FIRST   = 1,
  parameter int LEN_OFFSET  = DEF_LEN_OFFSET,
  parameter int FRAME_OVH   = DEF_FRAME_OVH,
  parameter int FIFO_DEPTH  = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rs422_clk,
  input  logic                          rs422_en,
  input  logic                          rs422_data,
  output logic                          tvalid,
  input  logic                          tready,
  output logic [DATA_W-1:0]             tdata,
  output logic                          tlast,
  output logic                          tuser,
  output logic                          rx_overflow,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int EW       = entry_w(DATA_W);
  localparam int LAST_POS = entry_last_pos(DATA_W);
  localparam int USER_POS = entry_user_pos(DATA_W);
  localparam int BW       = $clog2(DATA_W);
  localparam logic [LEN_W:0] OVH_EXT = (LEN_W+1)'(FRAME_OVH);
  localparam logic [LEN_W:0] MIN_END = (LEN_W+1)'(LEN_OFFSET + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, en_prev_q;
  logic                   s_clk, s_en, s_dat, sample, en_rise;

  logic [DATA_W-1:0]      shift_q, shift_d, word_new;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]       wcnt_q, wcnt_d;
  logic [LEN_W-1:0]       len_q, len_d, len_next;
  logic [LEN_BYTE_W-1:0]  len_byte;
  logic [LEN_W:0]         end_raw, end_idx;
  logic                   word_done, is_last;

  logic [DATA_W-1:0]      pend_data_q, pend_data_d;
  logic                   pend_vld_q, pend_vld_d, pend_last_q, pend_last_d;
  logic                   push_req, push_last, push_user;
  logic                   rx_overflow_q, rx_overflow_d, frame_err_q, frame_err_d;

  logic [EW-1:0]          wr_entry, rd_entry;
  logic                   fifo_empty, fifo_full;

  assign s_clk   = clk_sync_q[SYNC_STAGES-1];
  assign s_en    = en_sync_q[SYNC_STAGES-1];
  assign s_dat   = dat_sync_q[SYNC_STAGES-1];
  assign sample  = s_clk && !clk_prev_q && !s_en;
  assign en_rise = s_en && !en_prev_q;

  // Only the low byte of a header word carries length bits.
  if (DATA_W >= LEN_BYTE_W) begin : g_len_byte
    assign len_byte = word_new[LEN_BYTE_W-1:0];
  end else begin : g_len_byte
    assign len_byte = {{(LEN_BYTE_W-DATA_W){1'b0}}, word_new};
  end

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], rs422_clk};
    en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], rs422_en};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], rs422_data};

    if (MSB_FIRST != 0) begin
      word_new = {shift_q[DATA_W-2:0], s_dat};
    end else begin
      word_new = {s_dat, shift_q[DATA_W-1:1]};
    end
    word_done = sample && (bit_cnt_q == BW'(DATA_W - 1));

    // Length as it stands once the current word is included, so a header
    // word can itself be the end-of-frame word.
    len_next = len_q;
    if (wcnt_q == LEN_W'(LEN_OFFSET)) begin
      len_next[15:8] = len_byte;
    end
    if (wcnt_q == LEN_W'(LEN_OFFSET + 1)) begin
      len_next[7:0] = len_byte;
    end
    end_raw = {1'b0, len_next} + OVH_EXT - (LEN_W+1)'(1);
    end_idx = (end_raw <= MIN_END) ? MIN_END : end_raw;
    is_last = ({1'b0, wcnt_q} == end_idx);

    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    if (s_en) begin
      bit_cnt_d = '0;
      wcnt_d    = '0;
      len_d     = '0;
    end else if (sample) begin
      shift_d = word_new;
      if (word_done) begin
        bit_cnt_d = '0;
        if (is_last) begin
          wcnt_d = '0;
          len_d  = '0;
        end else begin
          wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
          len_d  = len_next;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // All FIFO writes come out of the pending register. An end-of-frame word
    // is parked there with its last flag and flushed on the following cycle,
    // which can never collide with another word completion.
    pend_data_d = pend_data_q;
    pend_vld_d  = pend_vld_q;
    pend_last_d = pend_last_q;
    push_req    = 1'b0;
    push_last   = 1'b0;
    push_user   = 1'b0;
    frame_err_d = 1'b0;
    if (pend_vld_q && pend_last_q) begin
      push_req   = 1'b1;
      push_last  = 1'b1;
      pend_vld_d = 1'b0;
    end else if (word_done) begin
      push_req    = pend_vld_q;
      pend_data_d = word_new;
      pend_vld_d  = 1'b1;
      pend_last_d = is_last;
    end else if (en_rise && pend_vld_q) begin
      push_req    = 1'b1;
      push_last   = 1'b1;
      push_user   = 1'b1;
      frame_err_d = 1'b1;
      pend_vld_d  = 1'b0;
    end
    rx_overflow_d = push_req && fifo_full;

    wr_entry                 = '0;
    wr_entry[DATA_W-1:0]     = pend_data_q;
    wr_entry[LAST_POS]       = push_last;
    wr_entry[USER_POS]       = push_user;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q    <= '0;
      en_sync_q     <= '1;
      dat_sync_q    <= '0;
      clk_prev_q    <= 1'b0;
      en_prev_q     <= 1'b1;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      wcnt_q        <= '0;
      len_q         <= '0;
      pend_data_q   <= '0;
      pend_vld_q    <= 1'b0;
      pend_last_q   <= 1'b0;
      rx_overflow_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      en_sync_q     <= en_sync_d;
      dat_sync_q    <= dat_sync_d;
      clk_prev_q    <= s_clk;
      en_prev_q     <= s_en;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      wcnt_q        <= wcnt_d;
      len_q         <= len_d;
      pend_data_q   <= pend_data_d;
      pend_vld_q    <= pend_vld_d;
      pend_last_q   <= pend_last_d;
      rx_overflow_q <= rx_overflow_d;
      frame_err_q   <= frame_err_d;
    end
  end

  rs422_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push_req),
    .wr_data (wr_entry),
    .rd_en   (tready),
    .rd_data (rd_entry),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign tvalid      = !fifo_empty;
  assign tdata       = rd_entry[DATA_W-1:0];
  assign tlast       = rd_entry[LAST_POS];
  assign tuser       = rd_entry[USER_POS];
  assign rx_overflow = rx_overflow_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_rs422_axis_rx_framer.sv
// Bench for rs422_axis_rx_framer: two instances (8-bit MSB-first depth 64, and
// 12-bit LSB-first depth 4) fed from one serial driver, checked against a
// queue of expected beats built from the framing rules.
module tb_rs422_axis_rx_framer;

  localparam int PH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, sel, s_clk, s_en, s_data;
  logic d0_clk, d0_en, d1_clk, d1_en;
  logic tready0, tready1, rnd1;

  logic        tvalid0, tlast0, tuser0, rx_overflow0, frame_err0;
  logic [7:0]  tdata0;
  logic [6:0]  level0;
  logic        tvalid1, tlast1, tuser1, rx_overflow1, frame_err1;
  logic [11:0] tdata1;
  logic [2:0]  level1;

  assign d0_clk = sel ? 1'b0 : s_clk;
  assign d0_en  = sel ? 1'b1 : s_en;
  assign d1_clk = sel ? s_clk : 1'b0;
  assign d1_en  = sel ? s_en : 1'b1;

  rs422_axis_rx_framer dut0 (
    .clk(clk), .rstn(rstn), .rs422_clk(d0_clk), .rs422_en(d0_en), .rs422_data(s_data),
    .tvalid(tvalid0), .tready(tready0), .tdata(tdata0), .tlast(tlast0), .tuser(tuser0),
    .rx_overflow(rx_overflow0), .frame_err(frame_err0), .fifo_level(level0)
  );

  rs422_axis_rx_framer #(.DATA_W(12), .MSB_FIRST(0), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rstn(rstn), .rs422_clk(d1_clk), .rs422_en(d1_en), .rs422_data(s_data),
    .tvalid(tvalid1), .tready(tready1), .tdata(tdata1), .tlast(tlast1), .tuser(tuser1),
    .rx_overflow(rx_overflow1), .frame_err(frame_err1), .fifo_level(level1)
  );

  int total = 0;
  int bad = 0;
  int ovf0 = 0, ovf1 = 0, ferr0 = 0, ferr1 = 0;
  logic [17:0] exp0[$];
  logic [17:0] exp1[$];
  logic [17:0] beat0, beat1, held0, held1;
  logic        stall0, stall1;

  assign beat0 = {tuser0, tlast0, 8'h00, tdata0};
  assign beat1 = {tuser1, tlast1, 4'h0, tdata1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic u, input logic l, input logic [15:0] d);
    return {u, l, d};
  endfunction

  function automatic int qsize(input bit d1);
    return d1 ? exp1.size() : exp0.size();
  endfunction

  task automatic push_exp(input bit d1, input logic [17:0] e);
    if (d1) exp1.push_back(e);
    else exp0.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      stall0 <= 1'b0;
    end else begin
      if (rx_overflow0) ovf0++;
      if (frame_err0) ferr0++;
      if (stall0) check("stall0", 32'({tvalid0, beat0}), 32'({1'b1, held0}));
      if (tvalid0 && tready0) begin
        if (exp0.size() == 0) check("beat0_unexpected", 32'(tvalid0), 0);
        else check("beat0", 32'(beat0), 32'(exp0.pop_front()));
      end
      stall0 <= tvalid0 && !tready0;
      held0  <= beat0;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      stall1 <= 1'b0;
    end else begin
      if (rx_overflow1) ovf1++;
      if (frame_err1) ferr1++;
      if (stall1) check("stall1", 32'({tvalid1, beat1}), 32'({1'b1, held1}));
      if (tvalid1 && tready1) begin
        if (exp1.size() == 0) check("beat1_unexpected", 32'(tvalid1), 0);
        else check("beat1", 32'(beat1), 32'(exp1.pop_front()));
      end
      stall1 <= tvalid1 && !tready1;
      held1  <= beat1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd1) tready1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic bit_out(input logic b);
    s_data = b;
    repeat (PH) @(negedge clk);
    s_clk = 1'b1;
    repeat (PH) @(negedge clk);
    s_clk = 1'b0;
  endtask

  task automatic word_out(input bit d1, input logic [15:0] w);
    int dw;
    dw = d1 ? 12 : 8;
    for (int i = 0; i < dw; i++) bit_out(d1 ? w[i] : w[dw-1-i]);
  endtask

  task automatic frame_begin();
    s_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clk);
    s_en = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Frame of len+7 words; header words 5/6 carry the length in their low byte.
  task automatic send_frame(input bit d1, input logic [15:0] len);
    int n;
    logic [15:0] w, mask;
    n = int'(len) + 7;
    mask = d1 ? 16'h0FFF : 16'h00FF;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom) & mask;
      if (i == 5) w = (w & 16'hFF00) | {8'h00, len[15:8]};
      if (i == 6) w = (w & 16'hFF00) | {8'h00, len[7:0]};
      push_exp(d1, mk(1'b0, i == n - 1, w));
      word_out(d1, w);
    end
  endtask

  task automatic wait_drain(input bit d1, input string tag);
    int k;
    k = 0;
    while (qsize(d1) != 0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(tag, 32'(qsize(d1)), 0);
  endtask

  initial begin
    int bo, bf;
    logic [15:0] w;
    sel = 1'b0; s_clk = 1'b0; s_en = 1'b1; s_data = 1'b0;
    tready0 = 1'b1; tready1 = 1'b1; rnd1 = 1'b0; rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset0", 32'({tvalid0, tlast0, tuser0, tdata0, rx_overflow0, frame_err0, level0}), 0);
    check("reset1", 32'({tvalid1, tlast1, tuser1, tdata1, rx_overflow1, frame_err1, level1}), 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // 7-word frame, length 0
    bo = ovf0; bf = ferr0;
    frame_begin();
    for (int i = 0; i < 7; i++) begin
      w = (i == 5 || i == 6) ? 16'h0 : 16'(i);
      push_exp(1'b0, mk(1'b0, i == 6, w));
      word_out(1'b0, w);
    end
    frame_end();
    wait_drain(1'b0, "t1_drain");
    check("t1_frame_err", 32'(ferr0 - bf), 0);

    // length 3 then a back-to-back length 0 frame in one enable window
    frame_begin();
    send_frame(1'b0, 16'd3);
    send_frame(1'b0, 16'd0);
    frame_end();
    wait_drain(1'b0, "t2_drain");
    check("t2_overflow", 32'(ovf0 - bo), 0);

    // abort after 4 words + 3 bits
    bf = ferr0;
    frame_begin();
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom_range(0, 255));
      push_exp(1'b0, mk(i == 3, i == 3, w));
      word_out(1'b0, w);
    end
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    frame_end();
    wait_drain(1'b0, "t3_drain");
    check("t3_frame_err", 32'(ferr0 - bf), 1);
    frame_begin();
    send_frame(1'b0, 16'd1);
    frame_end();
    wait_drain(1'b0, "t3_next_frame");
    check("t3_frame_err_after", 32'(ferr0 - bf), 1);

    // overflow on the 4-deep instance with tready held low
    sel = 1'b1; tready1 = 1'b0;
    bo = ovf1; bf = ferr1;
    frame_begin();
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom_range(0, 4095));
      if (i < 4) push_exp(1'b1, mk(1'b0, 1'b0, w));
      word_out(1'b1, w);
    end
    frame_end();
    repeat (5) @(negedge clk);
    check("t4_level", 32'(level1), 4);
    check("t4_tvalid", 32'(tvalid1), 1);
    check("t4_overflow", 32'(ovf1 - bo), 2);
    check("t4_frame_err", 32'(ferr1 - bf), 1);
    tready1 = 1'b1;
    wait_drain(1'b1, "t4_drain");
    check("t4_level_empty", 32'(level1), 0);

    // 12-bit LSB-first frames with random back-pressure
    bo = ovf1;
    rnd1 = 1'b1;
    frame_begin();
    send_frame(1'b1, 16'($urandom_range(0, 3)));
    send_frame(1'b1, 16'($urandom_range(0, 2)));
    frame_end();
    wait_drain(1'b1, "t5_drain");
    rnd1 = 1'b0;
    @(negedge clk);
    tready1 = 1'b1;
    check("t5_overflow", 32'(ovf1 - bo), 0);

    // reset mid-frame and mid-word with words queued
    sel = 1'b0; tready0 = 1'b0;
    frame_begin();
    for (int i = 0; i < 8; i++) word_out(1'b0, 16'($urandom_range(0, 255)));
    bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    check("t6_level_before", 32'(level0), 7);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6_reset0", 32'({tvalid0, tlast0, tuser0, tdata0, rx_overflow0, frame_err0, level0}), 0);
    check("t6_reset1", 32'({tvalid1, tlast1, tuser1, tdata1, rx_overflow1, frame_err1, level1}), 0);
    s_en = 1'b1; s_clk = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1; tready0 = 1'b1;
    repeat (5) @(negedge clk);
    frame_begin();
    send_frame(1'b0, 16'd2);
    frame_end();
    wait_drain(1'b0, "t6_clean_frame");
    check("t6_idle", 32'(tvalid0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
